// File: rtl/ring_ctrl_pkg.sv
// ring_ctrl_pkg: shared opcodes, rotate directions and sequencer state encoding
package ring_ctrl_pkg;
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_ROTATE = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_e;
endpackage

// File: rtl/ring_reg.sv
// ring_reg: ring shift register with parallel load and one-position rotate
module ring_reg
  import ring_ctrl_pkg::*;
#(
  parameter int SR_W = 8,
  parameter logic [SR_W-1:0] RESET_VAL = 8'hAA
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [SR_W-1:0] load_val,
  input  logic            shift_en,
  input  logic            dir,
  output logic [SR_W-1:0] ring
);
  always_ff @(posedge clk)
    if (rst) ring <= RESET_VAL;
    else if (load_en) ring <= load_val;
    else if (shift_en) ring <= (dir == DIR_RIGHT) ? {ring[0], ring[SR_W-1:1]} : {ring[SR_W-2:0], ring[SR_W-1]};
endmodule

// File: rtl/ring_seq_ctrl.sv
// ring_seq_ctrl: command sequencer (LOAD/ROTATE/CLEAR) driving a ring register
module ring_seq_ctrl
  import ring_ctrl_pkg::*;
#(
  parameter int SR_W = 8,
  parameter int CNT_W = 8,
  parameter logic [SR_W-1:0] RESET_VAL = 8'hAA
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic             cmd_dir_i,
  input  logic [SR_W-1:0]  cmd_data_i,
  input  logic [CNT_W-1:0] cmd_count_i,
  input  logic             step_en_i,
  input  logic             abort_i,
  output logic [SR_W-1:0]  ring_o,
  output logic [CNT_W-1:0] remaining_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o
);
  state_e state, state_n;
  logic [CNT_W-1:0] rem_n;
  logic dir_q, dir_n, ab_q, ab_n;
  logic load_en, shift_en;
  logic [SR_W-1:0] load_val;
  logic accept, rot_go;
  assign cmd_ready_o = (state == IDLE) & ~reset_i;
  assign accept = cmd_valid_i & cmd_ready_o;
  assign rot_go = (cmd_op_i == OP_ROTATE) && (cmd_count_i != '0);
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign aborted_o = done_o & ab_q;
  always_comb begin
    state_n = state;
    rem_n = remaining_o;
    dir_n = dir_q;
    ab_n = ab_q;
    load_en = 1'b0;
    load_val = (cmd_op_i == OP_CLEAR) ? RESET_VAL : cmd_data_i;
    shift_en = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        state_n = rot_go ? ROT : DONE;
        load_en = (cmd_op_i == OP_LOAD) || (cmd_op_i == OP_CLEAR);
        rem_n = rot_go ? cmd_count_i : remaining_o;
        dir_n = rot_go ? cmd_dir_i : dir_q;
      end
      ROT: begin
        // abort wins over a pending step, even the final one
        ab_n = abort_i;
        shift_en = step_en_i & ~abort_i;
        rem_n = shift_en ? remaining_o - CNT_W'(1) : remaining_o;
        state_n = (abort_i || (shift_en && remaining_o == CNT_W'(1))) ? DONE : ROT;
      end
      DONE: begin
        state_n = IDLE;
        ab_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      remaining_o <= '0;
      dir_q <= DIR_LEFT;
      ab_q <= 1'b0;
    end else begin
      state <= state_n;
      remaining_o <= rem_n;
      dir_q <= dir_n;
      ab_q <= ab_n;
    end
  ring_reg #(.SR_W(SR_W), .RESET_VAL(RESET_VAL)) u_ring (
    .clk(clk_i),
    .rst(reset_i),
    .load_en(load_en),
    .load_val(load_val),
    .shift_en(shift_en),
    .dir(dir_q),
    .ring(ring_o)
  );
endmodule

// File: tb/tb_ring_seq_ctrl.sv
// tb_ring_seq_ctrl: vector table, reset corner case and random commands vs a command-level model
module tb_ring_seq_ctrl;
  import ring_ctrl_pkg::*;
  localparam logic [7:0] RV = 8'hAA;
  logic clk = 0, reset_i = 1, cmd_valid_i = 0, cmd_dir_i = 0, step_en_i = 0, abort_i = 0;
  logic [1:0] cmd_op_i = 0;
  logic [7:0] cmd_data_i = 0, cmd_count_i = 0;
  logic cmd_ready_o, busy_o, done_o, aborted_o;
  logic [7:0] ring_o, remaining_o;
  int checks = 0, errors = 0;
  logic en_seq [64];
  logic ab_seq [64];
  logic [7:0] model_ring, model_rem;
  typedef struct {
    logic [1:0] op; logic dir; logic [7:0] data; logic [7:0] cnt;
    int st_s; int st_l; int ab_e;
    logic [7:0] e_ring; logic [7:0] e_rem; logic e_ab; int e_lat;
  } vec_t;
  vec_t vecs [12];

  ring_seq_ctrl #(.SR_W(8), .CNT_W(8), .RESET_VAL(RV)) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_dir_i(cmd_dir_i), .cmd_data_i(cmd_data_i), .cmd_count_i(cmd_count_i),
    .step_en_i(step_en_i), .abort_i(abort_i), .ring_o(ring_o), .remaining_o(remaining_o),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] v, input int k, input logic dir);
    int s;
    s = k % 8;
    if (s == 0) return v;
    return dir ? ((v >> s) | (v << (8 - s))) : ((v << s) | (v >> (8 - s)));
  endfunction

  task automatic fill_seq(input int st_s, input int st_l, input int ab_e);
    for (int i = 0; i < 64; i++) begin
      en_seq[i] = !((i + 1 >= st_s) && (i + 1 < st_s + st_l));
      ab_seq[i] = (i + 1 == ab_e);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic dir, input logic [7:0] data, input logic [7:0] cnt,
                        output logic [7:0] a_ring, output logic [7:0] a_rem, output logic a_ab, output int a_lat);
    int d, k, cyc;
    logic [7:0] e_ring, e_rem, start;
    logic e_ab;
    d = 0; k = 0; e_ab = 0; start = model_ring;
    if (op == OP_ROTATE && cnt != 0) begin
      for (int i = 1; i <= 64; i++) begin
        if (ab_seq[i-1]) begin e_ab = 1; d = i; break; end
        if (en_seq[i-1]) k++;
        if (k == int'(cnt)) begin d = i; break; end
      end
      e_ring = rot(start, k, dir);
      e_rem = cnt - 8'(k);
    end else begin
      e_ring = (op == OP_LOAD) ? data : (op == OP_CLEAR) ? RV : start;
      e_rem = model_rem;
    end
    chk("ready_before", cmd_ready_o, 1);
    cmd_valid_i = 1; cmd_op_i = op; cmd_dir_i = dir; cmd_data_i = data; cmd_count_i = cnt;
    step_en_i = 1'($urandom); abort_i = 1'($urandom);
    tick();
    k = 0; cyc = 0;
    while (!done_o && cyc < 80) begin
      chk("run_busy", busy_o, 1);
      chk("run_ready", cmd_ready_o, 0);
      chk("run_rem", remaining_o, cnt - 8'(k));
      chk("run_ring", ring_o, rot(start, k, dir));
      cmd_valid_i = 1'($urandom); cmd_op_i = OP_LOAD; cmd_data_i = 8'h5A; cmd_count_i = 8'($urandom);
      step_en_i = en_seq[cyc % 64]; abort_i = ab_seq[cyc % 64];
      tick();
      if (step_en_i && !abort_i) k++;
      cyc++;
    end
    a_ring = ring_o; a_rem = remaining_o; a_ab = aborted_o; a_lat = cyc;
    chk("latency", cyc, d);
    chk("done", done_o, 1);
    chk("ring", ring_o, e_ring);
    chk("remaining", remaining_o, e_rem);
    chk("aborted", aborted_o, e_ab);
    chk("done_busy", busy_o, 1);
    chk("done_ready", cmd_ready_o, 0);
    step_en_i = 1'($urandom); abort_i = 1'($urandom);
    tick();
    cmd_valid_i = 0; step_en_i = 0; abort_i = 0;
    chk("post_done", done_o, 0);
    chk("post_aborted", aborted_o, 0);
    chk("post_busy", busy_o, 0);
    chk("post_ready", cmd_ready_o, 1);
    chk("post_ring", ring_o, e_ring);
    chk("post_rem", remaining_o, e_rem);
    model_ring = e_ring;
    model_rem = e_rem;
  endtask

  initial begin
    logic [7:0] a_ring, a_rem;
    logic a_ab;
    int a_lat;
    vecs[0]  = '{OP_LOAD,   1'b0, 8'h81, 8'd0, 0, 0, 0, 8'h81, 8'd0, 1'b0, 0};
    vecs[1]  = '{OP_ROTATE, 1'b0, 8'h00, 8'd3, 0, 0, 0, 8'h0C, 8'd0, 1'b0, 3};
    vecs[2]  = '{OP_ROTATE, 1'b1, 8'h00, 8'd1, 0, 0, 0, 8'h06, 8'd0, 1'b0, 1};
    vecs[3]  = '{OP_LOAD,   1'b0, 8'h81, 8'd0, 0, 0, 0, 8'h81, 8'd0, 1'b0, 0};
    vecs[4]  = '{OP_ROTATE, 1'b0, 8'h00, 8'd8, 0, 0, 0, 8'h81, 8'd0, 1'b0, 8};
    vecs[5]  = '{OP_ROTATE, 1'b0, 8'h00, 8'd0, 0, 0, 0, 8'h81, 8'd0, 1'b0, 0};
    vecs[6]  = '{OP_NOP,    1'b0, 8'h3C, 8'd7, 0, 0, 0, 8'h81, 8'd0, 1'b0, 0};
    vecs[7]  = '{OP_LOAD,   1'b0, 8'h01, 8'd0, 0, 0, 0, 8'h01, 8'd0, 1'b0, 0};
    vecs[8]  = '{OP_ROTATE, 1'b0, 8'h00, 8'd4, 2, 2, 0, 8'h10, 8'd0, 1'b0, 6};
    vecs[9]  = '{OP_LOAD,   1'b0, 8'h01, 8'd0, 0, 0, 0, 8'h01, 8'd0, 1'b0, 0};
    vecs[10] = '{OP_ROTATE, 1'b0, 8'h00, 8'd5, 0, 0, 4, 8'h08, 8'd2, 1'b1, 4};
    vecs[11] = '{OP_CLEAR,  1'b0, 8'h00, 8'd0, 0, 0, 0, 8'hAA, 8'd2, 1'b0, 0};
    tick(); tick();
    chk("rst_ring", ring_o, RV);
    chk("rst_rem", remaining_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_aborted", aborted_o, 0);
    chk("rst_ready", cmd_ready_o, 0);
    reset_i = 0;
    #1;
    chk("rst_release_ready", cmd_ready_o, 1);
    model_ring = RV; model_rem = 0;
    foreach (vecs[i]) begin
      fill_seq(vecs[i].st_s, vecs[i].st_l, vecs[i].ab_e);
      do_cmd(vecs[i].op, vecs[i].dir, vecs[i].data, vecs[i].cnt, a_ring, a_rem, a_ab, a_lat);
      chk("vec_ring", a_ring, vecs[i].e_ring);
      chk("vec_rem", a_rem, vecs[i].e_rem);
      chk("vec_aborted", a_ab, vecs[i].e_ab);
      chk("vec_latency", a_lat, vecs[i].e_lat);
    end
    cmd_valid_i = 1; cmd_op_i = OP_ROTATE; cmd_dir_i = 0; cmd_count_i = 8'd5;
    tick();
    cmd_valid_i = 0; step_en_i = 1;
    tick(); tick();
    chk("pre_rst_busy", busy_o, 1);
    reset_i = 1;
    #1;
    chk("midrst_ready", cmd_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_ring", ring_o, RV);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_rem", remaining_o, 0);
      chk("midrst_ready", cmd_ready_o, 0);
    end
    reset_i = 0; step_en_i = 0;
    #1;
    chk("midrst_release_ready", cmd_ready_o, 1);
    tick();
    chk("midrst_after_done", done_o, 0);
    chk("midrst_after_busy", busy_o, 0);
    chk("midrst_after_ring", ring_o, RV);
    model_ring = RV; model_rem = 0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 64; i++) begin
        en_seq[i] = (i >= 32) ? 1'b1 : ($urandom % 4 != 0);
        ab_seq[i] = (i < 32) && ($urandom % 20 == 0);
      end
      do_cmd(2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), a_ring, a_rem, a_ab, a_lat);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
